// File: rtl/rst_seq_ctrl_if.sv
// Handshake bundle between the reset sequencer and the clock generator, repair engine and core.
// master = sequencer side, slave = environment side.
interface rst_seq_ctrl_if;
  logic       warm_rst_req_i;
  logic       clk_stable_i;
  logic       mem_repair_done_i;
  logic       prstn_o;
  logic       start_clk_o;
  logic       srstn_o;
  logic       mem_repair_req_o;
  logic       mem_repair_done_o;
  logic       run_stall_o;
  logic       seq_err_o;
  logic [2:0] state_o;

  modport master (
    input  warm_rst_req_i, clk_stable_i, mem_repair_done_i,
    output prstn_o, start_clk_o, srstn_o, mem_repair_req_o,
    output mem_repair_done_o, run_stall_o, seq_err_o, state_o
  );

  modport slave (
    output warm_rst_req_i, clk_stable_i, mem_repair_done_i,
    input  prstn_o, start_clk_o, srstn_o, mem_repair_req_o,
    input  mem_repair_done_o, run_stall_o, seq_err_o, state_o
  );
endinterface

// File: rtl/rst_seq_ctrl.sv
// Power-up / warm-reset sequencer: POR, clock start, system reset, memory repair, stall release.
// Optional repair timeout with error state enabled by defining RST_SEQ_REPAIR_TIMEOUT_EN.
module rst_seq_ctrl #(
  parameter int DELAY_CLOCKS   = 100,
  parameter int TIMEOUT_CLOCKS = 4096
) (
  input logic            clk_i,
  input logic            rst_i,
  rst_seq_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_POR   = 3'd0,
    S_CLK   = 3'd1,
    S_SYS   = 3'd2,
    S_REP   = 3'd3,
    S_STALL = 3'd4,
    S_RUN   = 3'd5,
    S_WARM  = 3'd6,
    S_ERR   = 3'd7
  } state_t;

`ifdef RST_SEQ_REPAIR_TIMEOUT_EN
  localparam int LIMIT = (DELAY_CLOCKS > TIMEOUT_CLOCKS) ? DELAY_CLOCKS : TIMEOUT_CLOCKS;
`else
  localparam int LIMIT = DELAY_CLOCKS;
`endif
  localparam int CNT_W = $clog2(LIMIT) + 1;
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(DELAY_CLOCKS - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = '1;
`ifdef RST_SEQ_REPAIR_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CLOCKS - 1);
`endif

  if (DELAY_CLOCKS < 1 || DELAY_CLOCKS > 65535 || TIMEOUT_CLOCKS < 1) begin : g_badParams
    $error("rst_seq_ctrl: DELAY_CLOCKS or TIMEOUT_CLOCKS out of range");
  end

  state_t           r_state, w_state;
  logic [CNT_W-1:0] r_cnt, w_cnt, w_cntInc;
  logic             r_porArm, w_porArm;
  logic             r_prstn, w_prstn;
  logic             r_startClk, w_startClk;
  logic             r_srstn, w_srstn;
  logic             r_repReq, w_repReq;
  logic             r_repDone, w_repDone;
  logic             r_stall, w_stall;
`ifdef RST_SEQ_REPAIR_TIMEOUT_EN
  logic             r_err, w_err;
`endif

  always_comb begin
    w_state    = r_state;
    w_cnt      = r_cnt;
    w_cntInc   = (r_cnt == CNT_SAT) ? r_cnt : r_cnt + 1'b1;
    w_porArm   = 1'b1;
    w_prstn    = r_prstn;
    w_startClk = r_startClk;
    w_srstn    = r_srstn;
    w_repReq   = r_repReq;
    w_repDone  = r_repDone;
    w_stall    = r_stall;
`ifdef RST_SEQ_REPAIR_TIMEOUT_EN
    w_err      = r_err;
`endif

    case (r_state)
      // The reset-release edge only arms the POR timer, so prstn rises DELAY_CLOCKS edges after it.
      S_POR: begin
        if (r_porArm) begin
          if (r_cnt == DLY_LAST) begin
            w_prstn    = 1'b1;
            w_startClk = 1'b1;
            w_state    = S_CLK;
          end else begin
            w_cnt = w_cntInc;
          end
        end
      end
      S_CLK: begin
        if (!bus.clk_stable_i) begin
          w_cnt = '0;
        end else if (r_cnt == DLY_LAST) begin
          w_state = S_SYS;
        end else begin
          w_cnt = w_cntInc;
        end
      end
      S_SYS: begin
        if (r_cnt == DLY_LAST) begin
          w_srstn  = 1'b1;
          w_repReq = 1'b1;
          w_state  = S_REP;
        end else begin
          w_cnt = w_cntInc;
        end
      end
      S_REP: begin
        if (bus.mem_repair_done_i) begin
          w_repReq  = 1'b0;
          w_repDone = 1'b1;
          w_state   = S_STALL;
        end
`ifdef RST_SEQ_REPAIR_TIMEOUT_EN
        else if (r_cnt == TO_LAST) begin
          w_repReq = 1'b0;
          w_srstn  = 1'b0;
          w_stall  = 1'b1;
          w_err    = 1'b1;
          w_state  = S_ERR;
        end else begin
          w_cnt = w_cntInc;
        end
`endif
      end
      S_STALL: begin
        if (r_cnt == DLY_LAST) begin
          w_stall = 1'b0;
          w_state = S_RUN;
        end else begin
          w_cnt = w_cntInc;
        end
      end
      S_RUN: begin
        if (bus.warm_rst_req_i) begin
          w_srstn = 1'b0;
          w_stall = 1'b1;
          w_state = S_WARM;
        end
      end
      S_WARM: begin
        if (r_cnt == DLY_LAST) begin
          w_state = S_SYS;
        end else begin
          w_cnt = w_cntInc;
        end
      end
      S_ERR: begin
        if (bus.warm_rst_req_i) begin
`ifdef RST_SEQ_REPAIR_TIMEOUT_EN
          w_err = 1'b0;
`endif
          w_state = S_WARM;
        end
      end
      default: w_state = S_POR;
    endcase

    if (w_state != r_state) begin
      w_cnt = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= S_POR;
      r_cnt      <= '0;
      r_porArm   <= 1'b0;
      r_prstn    <= 1'b0;
      r_startClk <= 1'b0;
      r_srstn    <= 1'b0;
      r_repReq   <= 1'b0;
      r_repDone  <= 1'b0;
      r_stall    <= 1'b1;
`ifdef RST_SEQ_REPAIR_TIMEOUT_EN
      r_err      <= 1'b0;
`endif
    end else begin
      r_state    <= w_state;
      r_cnt      <= w_cnt;
      r_porArm   <= w_porArm;
      r_prstn    <= w_prstn;
      r_startClk <= w_startClk;
      r_srstn    <= w_srstn;
      r_repReq   <= w_repReq;
      r_repDone  <= w_repDone;
      r_stall    <= w_stall;
`ifdef RST_SEQ_REPAIR_TIMEOUT_EN
      r_err      <= w_err;
`endif
    end
  end

  assign bus.prstn_o           = r_prstn;
  assign bus.start_clk_o       = r_startClk;
  assign bus.srstn_o           = r_srstn;
  assign bus.mem_repair_req_o  = r_repReq;
  assign bus.mem_repair_done_o = r_repDone;
  assign bus.run_stall_o       = r_stall;
  assign bus.state_o           = r_state;
`ifdef RST_SEQ_REPAIR_TIMEOUT_EN
  assign bus.seq_err_o         = r_err;
`else
  assign bus.seq_err_o         = 1'b0;
`endif

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Scoreboard bench for rst_seq_ctrl: a phase/duration reference model predicts every cycle's outputs.
// Honours RST_SEQ_REPAIR_TIMEOUT_EN the same way as the design.
module tb_rst_seq_ctrl;
  localparam int D = 4;
  localparam int T = 16;
  localparam int P_POR = 0, P_CLK = 1, P_SYS = 2, P_REP = 3;
  localparam int P_STALL = 4, P_RUN = 5, P_WARM = 6, P_ERR = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  rst_seq_ctrl_if bus();

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  logic [9:0] sbQ[$];

  int phase = P_POR;
  int age = 0;
  int stableRun = 0;
  bit everDone = 1'b0;

  // -2: done held high, -1: never answer, else cycles after req
  int doneDelay = 3;
  int reqAge = 0;

  always #5 clk = ~clk;

  rst_seq_ctrl #(.DELAY_CLOCKS(D), .TIMEOUT_CLOCKS(T)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus.master)
  );

  function automatic logic [9:0] modelOutputs();
    logic [2:0] st;
    st = 3'(phase);
    return {phase != P_POR, phase != P_POR,
            (phase == P_REP || phase == P_STALL || phase == P_RUN),
            phase == P_REP, everDone, phase != P_RUN, phase == P_ERR, st};
  endfunction

  task automatic enterPhase(input int p);
    phase = p;
    age = 0;
    stableRun = 0;
  endtask

  // Reference model: each phase lasts a fixed number of edges or until its handshake.
  always @(posedge clk) begin
    cycle++;
    if (rst) begin
      enterPhase(P_POR);
      everDone = 1'b0;
    end else begin
      age++;
      case (phase)
        P_POR:   if (age == D + 1) enterPhase(P_CLK);
        P_CLK: begin
          stableRun = bus.clk_stable_i ? stableRun + 1 : 0;
          if (stableRun == D) enterPhase(P_SYS);
        end
        P_SYS:   if (age == D) enterPhase(P_REP);
        P_REP: begin
          if (bus.mem_repair_done_i) begin
            everDone = 1'b1;
            enterPhase(P_STALL);
          end
`ifdef RST_SEQ_REPAIR_TIMEOUT_EN
          else if (age == T) enterPhase(P_ERR);
`endif
        end
        P_STALL: if (age == D) enterPhase(P_RUN);
        P_RUN:   if (bus.warm_rst_req_i) enterPhase(P_WARM);
        P_WARM:  if (age == D) enterPhase(P_SYS);
        P_ERR:   if (bus.warm_rst_req_i) enterPhase(P_WARM);
        default: enterPhase(P_POR);
      endcase
    end
    sbQ.push_back(modelOutputs());
  end

  task automatic checkOutput(input logic [9:0] expected);
    logic [9:0] got;
    got = {bus.prstn_o, bus.start_clk_o, bus.srstn_o, bus.mem_repair_req_o,
           bus.mem_repair_done_o, bus.run_stall_o, bus.seq_err_o, bus.state_o};
    checks++;
    if (got !== expected) begin
      errors++;
      $display("[TB] FAIL outputs cycle %0d: got %b expected %b (prstn,clk,srstn,req,done,stall,err,state)",
               cycle, got, expected);
    end
  endtask

  always @(negedge clk) begin
    if (sbQ.size() > 0) checkOutput(sbQ.pop_front());
  end

  // Repair engine responder.
  always @(negedge clk) begin
    if (doneDelay == -2) begin
      bus.mem_repair_done_i = 1'b1;
    end else if (bus.mem_repair_req_o) begin
      reqAge++;
      bus.mem_repair_done_i = (doneDelay >= 0) && (reqAge >= doneDelay);
    end else begin
      reqAge = 0;
      bus.mem_repair_done_i = 1'b0;
    end
  end

  task automatic applyStimulus(input logic stable, input logic warm);
    bus.clk_stable_i = stable;
    bus.warm_rst_req_i = warm;
    @(negedge clk);
  endtask

  task automatic applyReset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic warmPulse();
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0);
  endtask

  task automatic waitState(input int s, input int budget, input string name);
    int n;
    n = 0;
    while (int'(bus.state_o) != s && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (int'(bus.state_o) != s) begin
      errors++;
      $display("[TB] FAIL wait %s: state got %0d required %0d after %0d cycles", name, bus.state_o, s, n);
    end
  endtask

  initial begin
    bus.clk_stable_i = 1'b1;
    bus.warm_rst_req_i = 1'b0;
    bus.mem_repair_done_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    applyReset();
    waitState(P_RUN, 100, "nominal boot");

    warmPulse();
    waitState(P_RUN, 100, "warm in run");

    applyReset();
    waitState(P_CLK, 50, "glitch reach clk");
    repeat (3) applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    bus.clk_stable_i = 1'b1;
    waitState(P_RUN, 100, "glitch boot");

    doneDelay = 20;
    applyReset();
    waitState(P_REP, 100, "reach rep");
    repeat (2) applyStimulus(1'b1, 1'b0);
    applyReset();
    doneDelay = 2;
    waitState(P_RUN, 200, "restart after mid reset");

    doneDelay = -2;
    warmPulse();
    waitState(P_RUN, 100, "done pre-high");
    doneDelay = 3;

    warmPulse();
    waitState(P_STALL, 100, "reach stall");
    warmPulse();
    waitState(P_RUN, 100, "warm ignored in stall");

`ifdef RST_SEQ_REPAIR_TIMEOUT_EN
    doneDelay = -1;
    warmPulse();
    waitState(P_ERR, 200, "repair timeout");
    warmPulse();
    waitState(P_WARM, 10, "err to warm");
    doneDelay = 3;
    waitState(P_RUN, 200, "recover after error");
`endif

    repeat (600) begin
      rst = ($urandom_range(0, 99) < 2);
      if (!bus.mem_repair_req_o && $urandom_range(0, 9) == 0)
        doneDelay = ($urandom_range(0, 7) == 0) ? -2 : int'($urandom_range(0, 6));
      applyStimulus($urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0);
    end

    rst = 1'b0;
    doneDelay = 3;
    bus.clk_stable_i = 1'b1;
    bus.warm_rst_req_i = 1'b0;
    applyReset();
    waitState(P_RUN, 100, "final boot");
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rst_seq_ctrl.md
# rst_seq_ctrl

Synthesizable power-up and warm-reset sequencer for the CHERIoT-SAFE subsystem. It drives the same ordered bring-up the simulation bench performs: POR release, clock start, system reset release, memory repair, and run-stall release. Unlike the bench, it waits on handshakes from the clock generator and the memory-repair engine, and it accepts warm-reset requests. It sits between the top-level reset pad logic and the core/memory reset and stall inputs.

## Interface
Parameters:
- DELAY_CLOCKS, 100: cycles per timed stage; legal range 1..65535.
- TIMEOUT_CLOCKS, 4096: maximum wait for repair done. Used only with the timeout macro.

Ports:
- clk_i  in  1  free-running reference clock; all logic runs on its rising edge.
- rst_i  in  1  synchronous, active-high reset. Forces state S_POR.
- warm_rst_req_i  in  1  warm-reset request, level-sampled.
- clk_stable_i  in  1  clock generator lock indication.
- mem_repair_done_i  in  1  repair engine completion.
- prstn_o  out  1  POR reset, active-low.
- start_clk_o  out  1  clock generator enable.
- srstn_o  out  1  system reset, active-low.
- mem_repair_req_o  out  1  repair request level.
- mem_repair_done_o  out  1  latched repair-complete indication.
- run_stall_o  out  1  core stall; 1 = stalled.
- seq_err_o  out  1  sticky sequencing error.
- state_o  out  3  current state encoding, for debug.

## Operation
- All outputs are registered.
- Values while rst_i=1: prstn_o=0, start_clk_o=0, srstn_o=0, mem_repair_req_o=0, mem_repair_done_o=0, run_stall_o=1, seq_err_o=0, state_o=0.
- A single stage counter `cnt` clears on every state change.
- States and transitions:
  - S_POR(0): count. At cnt==DELAY_CLOCKS-1, set prstn_o=1 and go to S_CLK.
  - S_CLK(1): start_clk_o=1. cnt advances only while clk_stable_i=1 and clears to 0 when it is low. Needs DELAY_CLOCKS consecutive stable cycles, then go to S_SYS.
  - S_SYS(2): count. At DELAY_CLOCKS-1, set srstn_o=1 and go to S_REP.
  - S_REP(3): mem_repair_req_o=1. On mem_repair_done_i=1, drop the request, set mem_repair_done_o=1, and go to S_STALL.
  - S_STALL(4): count. At DELAY_CLOCKS-1, set run_stall_o=0 and go to S_RUN.
  - S_RUN(5): hold. On warm_rst_req_i=1, go to S_WARM.
  - S_WARM(6): srstn_o=0 and run_stall_o=1. prstn_o, start_clk_o and mem_repair_done_o are unchanged. Count; at DELAY_CLOCKS-1 go to S_SYS. The repair step is re-run, but mem_repair_done_o stays 1 throughout.
  - S_ERR(7): run_stall_o=1, srstn_o=0, seq_err_o=1. Exits only on rst_i, or on warm_rst_req_i (go to S_WARM and clear seq_err_o).
- warm_rst_req_i is ignored in S_POR, S_CLK, S_SYS, S_REP, S_STALL and S_WARM.
- clk_stable_i is ignored outside S_CLK.
- Counter width is $clog2 of the larger active limit, plus 1. The counter never wraps; it saturates.

## Timing
- Reference point: edge 0 is the first rising edge that samples rst_i=0.
- prstn_o goes 1 after edge DELAY_CLOCKS (registered).
- start_clk_o goes 1 on the same edge that prstn_o goes 1.
- With clk_stable_i already high, srstn_o goes 1 after edge 3·DELAY_CLOCKS.
- mem_repair_req_o goes 1 on the same edge as srstn_o. It drops one cycle after the edge that samples done=1; mem_repair_done_o rises on that same edge.
- run_stall_o falls DELAY_CLOCKS edges after mem_repair_done_o rises.
- Warm reset: srstn_o falls on the edge after the request is sampled.
- rst_i=1 in any state forces the reset values on the next edge. This includes a reset arriving mid-stage; the counter is lost.
- mem_repair_done_i already high on entry to S_REP: the request is asserted for exactly 1 cycle.

## Configuration
- RST_SEQ_REPAIR_TIMEOUT_EN defined: in S_REP, cnt counts every cycle. At cnt==TIMEOUT_CLOCKS-1 with mem_repair_done_i still 0, go to S_ERR and drop mem_repair_req_o. If done and timeout occur on the same cycle, done wins.
- Macro undefined: S_REP waits indefinitely, S_ERR is unreachable, and seq_err_o is tied to 0.

## Test plan
All scenarios use DELAY_CLOCKS=4 and TIMEOUT_CLOCKS=16.
- Nominal boot, with clk_stable_i=1 and done returned 3 cycles after req: prstn_o rises at edge 4 and srstn_o at edge 12; mem_repair_done_o rises 3 cycles after req; run_stall_o falls 4 cycles later; state_o=5.
- Clock glitch: clk_stable_i drops for 1 cycle after 3 stable cycles in S_CLK. The counter restarts, and srstn_o rises 4 cycles later than in the nominal case.
- Warm reset in S_RUN: a 1-cycle warm_rst_req_i pulse. srstn_o=0 and run_stall_o=1 on the next edge; prstn_o stays 1; the sequence re-runs S_SYS through S_RUN.
- Mid-sequence reset: rst_i pulsed for 1 cycle while in S_REP. All outputs return to reset values and the full sequence restarts from edge 0.
- Timeout, with the macro defined and done never asserted: seq_err_o=1 and state_o=7 after 16 cycles in S_REP. A subsequent warm_rst_req_i clears seq_err_o and re-enters S_WARM.
- Warm request during S_STALL: ignored, and run_stall_o still falls on schedule.
